// File: rtl/pb_keyscan.sv
// pb_keyscan: 21-button synchronizer, debouncer and press-event keycode FIFO.
// Define PB_KEYSCAN_AUTOREPEAT_EN to push the code of a lone held key again after a delay, then at a fixed rate.
module pb_keyscan #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  input  logic        key_ready,
  input  logic        ovf_clr,
  output logic        key_valid,
  output logic [4:0]  key_code,
  output logic [20:0] held,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("pb_keyscan: parameter out of range");
  end

  typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} db_state_e;

  db_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        held_upd;
  logic [20:0] sync1_q, sync_q, sync_prev_q;
  logic [20:0] held_q, held_d, pending_q, pending_d;
  logic [20:0] newbits, rpt_bits, req_bits, push_onehot;
  logic [4:0]  push_code;
  logic        push, pop, full;
  logic [4:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        key_valid_q, key_valid_d, overflow_q, overflow_d;
  logic [4:0]  key_code_q, key_code_d;

  // Debounce FSM: state register.
  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) state_q <= STABLE;
    else        state_q <= state_d;
  end

  // Debounce FSM: next state. held updates on the very cycle the count reaches DEBOUNCE_TICKS.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_upd = 1'b0;
    case (state_q)
      STABLE: if (sync_q != held_q) begin
        cnt_d   = 8'd1;
        state_d = SETTLE;
      end
      SETTLE: cnt_d = (sync_q != sync_prev_q) ? 8'd1 : cnt_q + 8'd1;
      default: state_d = STABLE;
    endcase
    if (state_d == SETTLE && cnt_d == 8'(DEBOUNCE_TICKS)) begin
      held_upd = 1'b1;
      state_d  = STABLE;
      cnt_d    = '0;
    end
  end

`ifdef PB_KEYSCAN_AUTOREPEAT_EN
  logic [15:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_phase_q, rpt_phase_d, single_held;

  // Repeat requests are suppressed on a held update so a release never yields a trailing code.
  always_comb begin
    single_held = (held_q != '0) && ((held_q & (held_q - 21'd1)) == '0);
    rpt_cnt_d   = rpt_cnt_q + 16'd1;
    rpt_phase_d = rpt_phase_q;
    rpt_bits    = '0;
    if (held_upd || !single_held) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rpt_cnt_q == (rpt_phase_q ? 16'(REPEAT_RATE - 1) : 16'(REPEAT_DELAY - 1))) begin
      rpt_bits    = held_q;
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b1;
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_bits = '0;
`endif

  // Event and FIFO datapath: press capture, lowest-index push, registered head.
  always_comb begin
    newbits     = held_upd ? (sync_q & ~held_q) : '0;
    held_d      = held_upd ? sync_q : held_q;
    req_bits    = newbits | rpt_bits;
    push_onehot = '0;
    push_code   = '0;
    for (int i = 20; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_onehot = 21'd1 << i;
        push_code   = 5'(i);
      end
    end
    pop        = key_valid_q && key_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    push       = (pending_q != '0) && (!full || pop);
    pending_d  = (pending_q & ~(push ? push_onehot : '0)) | (req_bits & ~pending_q);
    overflow_d = (overflow_q && !ovf_clr) || ((req_bits & pending_q) != '0);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    key_valid_d = (count_d != '0);
    if (count_d == '0)                         key_code_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d))   key_code_d = push_code;
    else                                       key_code_d = mem_q[rd_ptr_d];
  end

  // NOTE: the FIFO storage has no reset; count and head registers alone define what is valid.
  always_ff @(posedge hz100) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      cnt_q       <= '0;
      held_q      <= '0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= pb;
      sync_q      <= sync1_q;
      sync_prev_q <= sync_q;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      pending_q   <= pending_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign held      = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pb_keyscan.sv
// tb_pb_keyscan: directed self-checking bench for pb_keyscan (default parameters).
// Inputs are driven and outputs sampled on the falling edge; "cycle n" means after the n-th rising edge.
module tb_pb_keyscan;

  logic        hz100 = 1'b0;
  logic        reset = 1'b0;
  logic [20:0] pb = '0;
  logic        key_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [20:0] held;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  pb_keyscan dut (
    .hz100    (hz100),
    .reset    (reset),
    .pb       (pb),
    .key_ready(key_ready),
    .ovf_clr  (ovf_clr),
    .key_valid(key_valid),
    .key_code (key_code),
    .held     (held),
    .overflow (overflow)
  );

  always #5 hz100 = ~hz100;

  typedef struct {
    logic [20:0] press;
    int          ncodes;
    logic [14:0] codes;   // {third, second, first}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge hz100);
  endtask

  // Clean press from idle: held at cycle 7, codes on cycles 8.., then release yields nothing.
  task automatic run_vec(input vec_t v, input int idx);
    logic seen;
    key_ready = 1'b1;
    pb = v.press;
    for (int n = 1; n <= 8 + v.ncodes; n++) begin
      @(negedge hz100);
      if (n == 6) check($sformatf("v%0d_held_c6", idx), held, 0);
      if (n == 7) begin
        check($sformatf("v%0d_held_c7", idx), held, v.press);
        check($sformatf("v%0d_valid_c7", idx), key_valid, 0);
      end
      if (n >= 8 && n < 8 + v.ncodes) begin
        check($sformatf("v%0d_valid_c%0d", idx, n), key_valid, 1);
        check($sformatf("v%0d_code_c%0d", idx, n), key_code, v.codes[(n-8)*5 +: 5]);
      end
      if (n == 8 + v.ncodes) check($sformatf("v%0d_valid_end", idx), key_valid, 0);
    end
    pb = '0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge hz100);
      if (key_valid) seen = 1'b1;
    end
    check($sformatf("v%0d_release_held", idx), held, 0);
    check($sformatf("v%0d_release_nocode", idx), seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic seen;
    int   ncodes;
    int   cyc [8];
    int   exp_seq [5];

    vecs[0] = '{press: 21'h000008, ncodes: 1, codes: {5'd0,  5'd0,  5'd3}};
    vecs[1] = '{press: 21'h100201, ncodes: 3, codes: {5'd20, 5'd9,  5'd0}};
    vecs[2] = '{press: 21'h100000, ncodes: 1, codes: {5'd0,  5'd0,  5'd20}};
    vecs[3] = '{press: 21'h000001, ncodes: 1, codes: {5'd0,  5'd0,  5'd0}};
    vecs[4] = '{press: 21'h00C000, ncodes: 2, codes: {5'd0,  5'd15, 5'd14}};
    vecs[5] = '{press: 21'h080010, ncodes: 2, codes: {5'd0,  5'd19, 5'd4}};

    // Reset state
    step(2);
    check("rst_held", held, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    step(3);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Bouncing pb[7]: 20 cycles of toggling, then a final rise.
    key_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pb[7] = ((i / 2) % 2 == 0);
      @(negedge hz100);
      if (held != '0 || key_valid) seen = 1'b1;
    end
    pb[7] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge hz100);
      if (n < 7 && (held != '0 || key_valid)) seen = 1'b1;
      if (n == 7) check("bounce_held_c7", held, 21'h80);
      if (n == 8) begin
        check("bounce_valid_c8", key_valid, 1);
        check("bounce_code_c8", key_code, 7);
      end
      if (n == 9) check("bounce_single_code", key_valid, 0);
    end
    check("bounce_quiet", seen, 0);
    pb = '0;
    step(12);

    // FIFO fill, overflow set / clear / simultaneous set+clear, drain with full push+pop.
    key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pb[k] = 1'b1;
      step(10);
    end
    check("fill_valid", key_valid, 1);
    check("fill_head", key_code, 1);
    check("fill_no_ovf", overflow, 0);
    pb[5] = 1'b0;
    step(10);
    pb[5] = 1'b1;
    step(10);
    check("ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    pb[5] = 1'b0;
    step(10);
    pb[5] = 1'b1;
    step(6);
    check("ovf_before_drop", overflow, 0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_set_wins_clr", overflow, 1);
    check("ovf_held5", held[5], 1);
    exp_seq = '{1, 2, 3, 4, 5};
    key_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain_valid%0d", k), key_valid, 1);
      check($sformatf("drain_code%0d", k), key_code, exp_seq[k]);
      step(1);
    end
    check("drain_empty", key_valid, 0);
    pb = '0;
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    step(12);

    // Reset with two codes queued discards them.
    key_ready = 1'b0;
    pb[6] = 1'b1;
    pb[8] = 1'b1;
    step(10);
    check("q2_valid", key_valid, 1);
    check("q2_head", key_code, 6);
    pb = '0;
    reset = 1'b0;
    #1;
    check("async_rst_valid", key_valid, 0);
    check("async_rst_code", key_code, 0);
    check("async_rst_held", held, 0);
    step(2);
    reset = 1'b1;
    key_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge hz100);
      if (key_valid) seen = 1'b1;
    end
    check("post_rst_nothing", seen, 0);

    // Button held through reset is reported once debounced.
    pb[11] = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge hz100);
      if (n == 6) check("thru_rst_held_c6", held, 0);
      if (n == 7) check("thru_rst_held_c7", held, 21'h800);
      if (n == 8) check("thru_rst_code_c8", key_code, 11);
      if (n == 9) check("thru_rst_once", key_valid, 0);
    end
    pb = '0;
    step(12);

    // pb[2] held 80 cycles: count emitted codes and when they appear.
    ncodes = 0;
    cyc = '{default: 0};
    pb[2] = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(negedge hz100);
      if (key_valid) begin
        if (ncodes < 8) cyc[ncodes] = n;
        ncodes++;
      end
      if (n == 80) pb = '0;
    end
    check("hold_first_cycle", cyc[0], 8);
`ifdef PB_KEYSCAN_AUTOREPEAT_EN
    check("hold_ncodes", ncodes, 4);
    check("hold_rpt1_cycle", cyc[1], 58);
    check("hold_rpt2_cycle", cyc[2], 68);
    check("hold_rpt3_cycle", cyc[3], 78);
`else
    check("hold_ncodes", ncodes, 1);
`endif
    check("hold_released", held, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
